mul_sequencer: RTL and testbench

Iterative multi-cycle sequencer for the RV32M multiply instructions (MUL, MULH, MULHSU, MULHU) in the custom processor. It sits beside the single-cycle ALU in the execute stage. It decodes the instruction word in parallel with the control logic, captures the operands, and runs a radix-2 shift-add multiply over 32 iterations. While it runs it holds the pipeline stalled, then returns one result word with a single-cycle valid pulse.

---
 rtl/mul_sequencer_if.sv | 26 ++
 rtl/mul_sequencer.sv | 167 ++++++++++++++++
 tb/tb_mul_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/mul_sequencer_if.sv
// Execute-stage handshake between the pipeline and the multiply sequencer.
// Master = pipeline/execute control, slave = mul_sequencer.
interface mul_sequencer_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [31:0]     instruction;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic            flush;
  logic            stall;
  logic            busy;
  logic [XLEN-1:0] result;
  logic            result_valid;
  logic            illegal;

  modport master (
    output start, instruction, rs1_val, rs2_val, flush,
    input  stall, busy, result, result_valid, illegal
  );

  modport slave (
    input  start, instruction, rs1_val, rs2_val, flush,
    output stall, busy, result, result_valid, illegal
  );
endinterface

// File: rtl/mul_sequencer.sv
// Radix-2 shift-add sequencer for RV32M MUL/MULH/MULHSU/MULHU.
// MUL_HIGH_EN enables the high-word encodings and the SIGN state.
module mul_sequencer #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  mul_sequencer_if.slave bus
);
  localparam int CW = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              illegal_q, illegal_d;

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       is_mul;
  logic       supported;
  logic       accept;
  logic       unused_instr;

  assign opcode = bus.instruction[6:0];
  assign funct3 = bus.instruction[14:12];
  assign funct7 = bus.instruction[31:25];
  assign unused_instr = ^{bus.instruction[24:15],
                          bus.instruction[11:7]};

  assign is_mul = (opcode == 7'b0110011)
               && (funct7 == 7'b0000001)
               && !funct3[2];

  logic s1, s2;
`ifdef MUL_HIGH_EN
  assign supported = 1'b1;
  assign s1 = (funct3 == 3'b001) || (funct3 == 3'b010);
  assign s2 = (funct3 == 3'b001);
`else
  assign supported = (funct3[1:0] == 2'b00);
  assign s1 = 1'b0;
  assign s2 = 1'b0;
`endif

  assign accept = (state_q == IDLE) && bus.start && is_mul
               && supported && !bus.flush;

  logic            neg1, neg2;
  logic [XLEN-1:0] mag1, mag2;

  assign neg1 = s1 & bus.rs1_val[XLEN-1];
  assign neg2 = s2 & bus.rs2_val[XLEN-1];
  assign mag1 = neg1 ? -bus.rs1_val : bus.rs1_val;
  assign mag2 = neg2 ? -bus.rs2_val : bus.rs2_val;

  // Lower half of acc holds the multiplier and shifts out as product bits.
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] shifted;
  logic              last;

  assign sum = {1'b0, acc_q[2*XLEN-1:XLEN]}
             + (acc_q[0] ? {1'b0, mcand_q} : '0);
  assign shifted = {sum, acc_q[XLEN-1:1]};
  assign last = (cnt_q == CW'(XLEN - 1));

`ifdef MUL_HIGH_EN
  logic              neg_q, neg_d;
  logic [2:0]        f3_q, f3_d;
  logic [2*XLEN-1:0] prod_fix;

  assign neg_d    = accept ? (neg1 ^ neg2) : neg_q;
  assign f3_d     = accept ? funct3 : f3_q;
  assign prod_fix = neg_q ? -acc_q : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      neg_q <= 1'b0;
      f3_q  <= 3'b000;
    end else begin
      neg_q <= neg_d;
      f3_q  <= f3_d;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      mcand_q   <= '0;
      result_q  <= '0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      mcand_q   <= mcand_d;
      result_q  <= result_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = CALC;
`ifdef MUL_HIGH_EN
      CALC: if (last) state_d = SIGN;
      SIGN: state_d = DONE;
`else
      CALC: if (last) state_d = DONE;
`endif
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) state_d = IDLE;
  end

  always_comb begin
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    illegal_d = (state_q == IDLE) && bus.start && is_mul
             && !supported && !bus.flush;
    if (accept) begin
      acc_d   = {{XLEN{1'b0}}, mag2};
      mcand_d = mag1;
      cnt_d   = '0;
    end else if (state_q == CALC) begin
      acc_d = shifted;
      cnt_d = cnt_q + CW'(1);
`ifndef MUL_HIGH_EN
      if (last && !bus.flush) result_d = shifted[XLEN-1:0];
`endif
    end
`ifdef MUL_HIGH_EN
    else if (state_q == SIGN) begin
      acc_d = prod_fix;
      if (!bus.flush) begin
        result_d = (f3_q == 3'b000) ? prod_fix[XLEN-1:0]
                                    : prod_fix[2*XLEN-1:XLEN];
      end
    end
`endif
  end

  always_comb begin
    bus.stall        = accept || (state_q == CALC)
                    || (state_q == SIGN);
    bus.busy         = (state_q != IDLE);
    bus.result_valid = (state_q == DONE);
    bus.result       = result_q;
    bus.illegal      = illegal_q;
  end
endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: directed steps plus random operands
// checked against a 64-bit arithmetic product model.
module tb_mul_sequencer;
  localparam int XLEN = 32;
`ifdef MUL_HIGH_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  mul_sequencer_if #(.XLEN(XLEN)) bus();

  mul_sequencer #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] f3,
                                     input logic [6:0] f7);
    return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
  endfunction

  function automatic logic [31:0] model(input logic [2:0] f3,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] xa, xb, p;
    xa = {32'b0, a};
    xb = {32'b0, b};
    if (f3 == 3'b001 || f3 == 3'b010) xa = {{32{a[31]}}, a};
    if (f3 == 3'b001) xb = {{32{b[31]}}, b};
    p = xa * xb;
    return (f3 == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  // Called at #1 into a cycle with the sequencer idle.
  task automatic do_mul(input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input string tag);
    int cyc;
    bit got, run_ok;
    logic [31:0] exp;
    exp = model(f3, a, b);
    bus.start = 1'b1;
    bus.instruction = mk(f3, 7'b0000001);
    bus.rs1_val = a;
    bus.rs2_val = b;
    #1;
    chk({tag, "_req_stall"}, bus.stall, 1);
    @(posedge clk); #1;
    bus.instruction = mk(3'b000, 7'b0000001);
    cyc = 1;
    got = 0;
    run_ok = 1;
    while (!got && cyc < LAT + 20) begin
      if (bus.result_valid) got = 1;
      else begin
        if (bus.stall !== 1'b1 || bus.busy !== 1'b1) run_ok = 0;
        bus.rs1_val = $urandom;
        bus.rs2_val = $urandom;
        @(posedge clk); #1;
        cyc++;
      end
    end
    bus.start = 1'b0;
    chk({tag, "_valid_seen"}, got, 1);
    chk({tag, "_latency"}, cyc, LAT);
    chk({tag, "_stall_run"}, run_ok, 1);
    chk({tag, "_stall_done"}, bus.stall, 0);
    chk({tag, "_result"}, bus.result, exp);
    last_res = exp;
    @(posedge clk); #1;
    chk({tag, "_idle"}, bus.busy, 0);
    chk({tag, "_pulse"}, bus.result_valid, 0);
    chk({tag, "_held"}, bus.result, exp);
  endtask

  initial begin
    logic [2:0] f3;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.instruction = '0;
    bus.rs1_val = '0;
    bus.rs2_val = '0;
    last_res = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stall", bus.stall, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_valid", bus.result_valid, 0);
    chk("rst_illegal", bus.illegal, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    do_mul(3'b000, 32'd7, 32'hFFFFFFFD, "mul_7_m3");
    chk("mul_7_m3_const", bus.result, 32'hFFFFFFEB);
`ifdef MUL_HIGH_EN
    do_mul(3'b001, 32'h80000000, 32'h80000000, "mulh_min");
    chk("mulh_min_const", bus.result, 32'h40000000);
    do_mul(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhu_max");
    chk("mulhu_max_const", bus.result, 32'hFFFFFFFE);
    do_mul(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1");
    chk("mulhsu_m1_const", bus.result, 32'hFFFFFFFF);
`else
    bus.start = 1'b1;
    bus.instruction = mk(3'b001, 7'b0000001);
    #1;
    chk("mulh_ill_stall", bus.stall, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("mulh_ill_pulse", bus.illegal, 1);
    chk("mulh_ill_busy", bus.busy, 0);
    @(posedge clk); #1;
    chk("mulh_ill_clear", bus.illegal, 0);
    chk("mulh_ill_busy2", bus.busy, 0);
`endif

    // DIV encoding and a plain ADD must be ignored.
    bus.start = 1'b1;
    bus.instruction = mk(3'b100, 7'b0000001);
    #1;
    chk("div_stall", bus.stall, 0);
    @(posedge clk); #1;
    chk("div_busy", bus.busy, 0);
    chk("div_illegal", bus.illegal, 0);
    bus.instruction = mk(3'b000, 7'b0000000);
    #1;
    chk("add_stall", bus.stall, 0);
    @(posedge clk); #1;
    chk("add_busy", bus.busy, 0);
    bus.start = 1'b0;

    // flush beats start in the request cycle
    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.instruction = mk(3'b000, 7'b0000001);
    #1;
    chk("fl_start_stall", bus.stall, 0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("fl_start_busy", bus.busy, 0);

    // flush at cycle 10 of a MUL, then MUL 3x5 next cycle
    bus.start = 1'b1;
    bus.instruction = mk(3'b000, 7'b0000001);
    bus.rs1_val = $urandom;
    bus.rs2_val = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("fl_mid_busy", bus.busy, 1);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("fl_idle", bus.busy, 0);
    chk("fl_stall", bus.stall, 0);
    chk("fl_novalid", bus.result_valid, 0);
    chk("fl_result_kept", bus.result, last_res);
    do_mul(3'b000, 32'd3, 32'd5, "after_flush");
    chk("after_flush_const", bus.result, 32'd15);

    for (int i = 0; i < 12; i++) begin
`ifdef MUL_HIGH_EN
      f3 = 3'($urandom_range(0, 3));
`else
      f3 = 3'b000;
`endif
      do_mul(f3, $urandom, $urandom, $sformatf("rand%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
